// File: rtl/bcd_serial_sequencer.sv
// Sequences packed BCD operands digit by digit through an external serial BCD adder
// and collects the digit sums, plus the final carry, into a packed BCD result.
module bcd_serial_sequencer #(
  parameter int N_DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [4*N_DIGITS-1:0]     op_a,
  input  logic [4*N_DIGITS-1:0]     op_b,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [4*(N_DIGITS+1)-1:0] result,
  output logic                      bcd_err,
  output logic [3:0]                add_a,
  output logic [3:0]                add_b,
  output logic                      add_start,
  output logic                      add_done,
  input  logic [3:0]                add_sum
);

  localparam int OP_W  = 4 * N_DIGITS;
  localparam int RES_W = 4 * (N_DIGITS + 1);
  localparam int CNT_W = $clog2(N_DIGITS + 2);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, OUT} state_t;

  state_t           state, state_next;
  logic [OP_W-1:0]  sh_a, sh_b;
  logic [CNT_W-1:0] cnt;
  logic [RES_W-1:0] res_q;
  logic             err_q;
  logic             accept;
  logic             last_digit;

  function automatic logic has_bad_digit(input logic [OP_W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  assign accept     = in_valid && in_ready;
  // One extra RUN cycle beyond the operand digits lets the adder's carry land as the top digit
  assign last_digit = (cnt == CNT_W'(N_DIGITS));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sh_a  <= '0;
      sh_b  <= '0;
      cnt   <= '0;
      res_q <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sh_a  <= op_a;
            sh_b  <= op_b;
            cnt   <= '0;
            res_q <= '0;
            err_q <= has_bad_digit(op_a) | has_bad_digit(op_b);
          end
        end
        RUN: begin
          res_q <= {add_sum, res_q[RES_W-1:4]};
          sh_a  <= sh_a >> 4;
          sh_b  <= sh_b >> 4;
          cnt   <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    res_valid  = 1'b0;
    add_a      = 4'd0;
    add_b      = 4'd0;
    add_start  = 1'b0;
    add_done   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        add_a     = sh_a[3:0];
        add_b     = sh_b[3:0];
        add_start = (cnt == '0);
        if (last_digit) state_next = FLUSH;
      end
      FLUSH: begin
        // Done pulse with zero operands clears the adder's carry for the next operation
        add_done   = 1'b1;
        state_next = OUT;
      end
      OUT: begin
        res_valid = 1'b1;
        if (res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign result  = res_q;
  assign bcd_err = err_q;

endmodule

// File: tb/tb_bcd_serial_sequencer.sv
// Bench for bcd_serial_sequencer with a behavioural serial BCD adder attached and a
// queue scoreboard of decimal-computed expected sums.
module tb_bcd_serial_sequencer;

  localparam int N_DIGITS = 4;
  localparam int OP_W     = 4 * N_DIGITS;
  localparam int RES_W    = 4 * (N_DIGITS + 1);

  typedef struct {
    logic [RES_W-1:0] res;
    logic             err;
  } exp_t;

  logic             clk;
  logic             rstn;
  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  op_a, op_b;
  logic             res_valid;
  logic             res_ready;
  logic [RES_W-1:0] result;
  logic             bcd_err;
  logic [3:0]       add_a, add_b, add_sum;
  logic             add_start, add_done;

  logic             carry;
  logic [4:0]       raw, adj;

  int   total;
  int   bad;
  exp_t sb[$];

  bcd_serial_sequencer #(.N_DIGITS(N_DIGITS)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .res_valid(res_valid), .res_ready(res_ready),
    .result(result), .bcd_err(bcd_err), .add_a(add_a), .add_b(add_b),
    .add_start(add_start), .add_done(add_done), .add_sum(add_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Serial BCD adder: combinational digit sum, carry register cleared by done or reset
  always_comb begin
    raw     = {1'b0, add_a} + {1'b0, add_b} + {4'd0, carry};
    adj     = raw - 5'd10;
    add_sum = (raw > 5'd9) ? adj[3:0] : raw[3:0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         carry <= 1'b0;
    else if (add_done) carry <= 1'b0;
    else               carry <= (raw > 5'd9);
  end

  function automatic logic [RES_W-1:0] bcdAdd(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
    logic [RES_W-1:0] r;
    int               c, s;
    r = '0;
    c = 0;
    for (int i = 0; i < N_DIGITS; i++) begin
      s = int'(a[4*i +: 4]) + int'(b[4*i +: 4]) + c;
      if (s > 9) begin s = s - 10; c = 1; end
      else c = 0;
      r[4*i +: 4] = 4'(s);
    end
    r[4*N_DIGITS +: 4] = 4'(c);
    return r;
  endfunction

  function automatic logic [OP_W-1:0] randBcd();
    logic [OP_W-1:0] v;
    for (int i = 0; i < N_DIGITS; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Offers one operand pair, scrambles the inputs after acceptance and queues the expectation
  task automatic applyStimulus(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b, input logic err);
    exp_t e;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    checkOutput("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op_a     = OP_W'($urandom);
    op_b     = OP_W'($urandom);
    e.res    = bcdAdd(a, b);
    e.err    = err;
    sb.push_back(e);
  endtask

  task automatic waitResult(input int hold);
    int   lat, starts, dones, both, rdy;
    exp_t e;
    lat = 1; starts = 0; dones = 0; both = 0; rdy = 0;
    while (!res_valid && lat < 40) begin
      starts += int'(add_start);
      dones  += int'(add_done);
      both   += int'(add_start && add_done);
      rdy    += int'(in_ready);
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("latency", 32'(lat), 32'(N_DIGITS + 3));
    checkOutput("start_pulses", 32'(starts), 32'd1);
    checkOutput("done_pulses", 32'(dones), 32'd1);
    checkOutput("start_done_overlap", 32'(both), 32'd0);
    checkOutput("in_ready_busy", 32'(rdy), 32'd0);
    if (sb.size() == 0) begin
      checkOutput("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    for (int i = 0; i <= hold; i++) begin
      checkOutput("res_valid", 32'(res_valid), 32'd1);
      checkOutput("bcd_err", 32'(bcd_err), 32'(e.err));
      if (!e.err) checkOutput("result", 32'(result), 32'(e.res));
      if (i > 0) checkOutput("in_ready_out", 32'(in_ready), 32'd0);
      if (i < hold) begin
        @(posedge clk);
        #1;
      end
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    checkOutput("res_valid_drop", 32'(res_valid), 32'd0);
    checkOutput("in_ready_back", 32'(in_ready), 32'd1);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rstn      = 1'b0;
    in_valid  = 1'b0;
    res_ready = 1'b0;
    op_a      = '0;
    op_b      = '0;
    #12;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
    checkOutput("rst_result", 32'(result), 32'd0);
    checkOutput("rst_bcd_err", 32'(bcd_err), 32'd0);
    checkOutput("rst_adder_ctl", {28'd0, add_start, add_done, 2'b00}, 32'd0);
    checkOutput("rst_add_ab", {24'd0, add_a, add_b}, 32'd0);
    rstn = 1'b1;

    applyStimulus(16'h0123, 16'h0480, 1'b0);
    waitResult(0);
    checkOutput("ref_0123_0480", 32'(bcdAdd(16'h0123, 16'h0480)), 32'h00603);

    applyStimulus(16'h9999, 16'h0001, 1'b0);
    waitResult(0);

    applyStimulus(16'h0000, 16'h0000, 1'b0);
    waitResult(0);

    applyStimulus(16'h4567, 16'h5678, 1'b0);
    waitResult(3);

    applyStimulus(16'h00A0, 16'h0001, 1'b1);
    waitResult(0);

    for (int k = 0; k < 4; k++) begin
      logic [OP_W-1:0] a, b;
      a = randBcd();
      b = randBcd();
      applyStimulus(a, b, 1'b0);
      waitResult(k % 2);
    end

    // Abort a carry-heavy run on its third RUN cycle
    applyStimulus(16'h9999, 16'h9999, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    sb.delete();
    checkOutput("abort_res_valid", 32'(res_valid), 32'd0);
    checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
    checkOutput("abort_add_start", 32'(add_start), 32'd0);
    #2;
    rstn = 1'b1;
    applyStimulus(16'h0005, 16'h0005, 1'b0);
    waitResult(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
